// File: rtl/kgp_risc_seq_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle control sequencer.
// Holds opcode/funct values, FSM state and instruction-class enums,
// pc_src / wb_sel mux selects, and the conditional-branch evaluator.
package kgp_risc_seq_ctrl_pkg;

  localparam logic [5:0] OP_RALU = 6'd0;
  localparam logic [5:0] OP_IALU = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_UNC  = 6'd4;
  localparam logic [5:0] OP_COND = 6'd5;
  localparam logic [5:0] OP_HALT = 6'd6;

  // Unconditional branch functs
  localparam logic [4:0] F_B  = 5'd0;
  localparam logic [4:0] F_BR = 5'd1;
  localparam logic [4:0] F_BL = 5'd2;

  // Conditional branch functs
  localparam logic [4:0] F_BLTZ = 5'd0;
  localparam logic [4:0] F_BZ   = 5'd1;
  localparam logic [4:0] F_BNZ  = 5'd2;
  localparam logic [4:0] F_BCY  = 5'd3;
  localparam logic [4:0] F_BNCY = 5'd4;

  localparam logic [4:0] ALU_ADD = 5'd0;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
  } state_t;

  typedef enum logic [3:0] {
    CL_RALU, CL_IALU, CL_LW, CL_SW, CL_B, CL_BR, CL_BL, CL_COND, CL_HALT, CL_ILL
  } iclass_t;

  // Branch decision for the conditional class, using flags as seen this cycle.
  function automatic logic cond_taken(input logic [4:0] funct,
                                      input logic z, input logic n, input logic c);
    logic t;
    case (funct)
      F_BLTZ:  t = n;
      F_BZ:    t = z;
      F_BNZ:   t = ~z;
      F_BCY:   t = c;
      F_BNCY:  t = ~c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/kgp_risc_seq_ctrl_decoder.sv
// Combinational instruction decoder for the KGP-RISC sequencer.
// Ports:
//   instr_i   - instruction word ([31:26] opcode, [4:0] funct)
//   iclass_o  - instruction class (CL_ILL when not a legal encoding)
//   alu_op_o  - ALU function (funct for R/I ALU, ADD for loads/stores)
//   alu_src_o - 0 = register rt, 1 = immediate
//   legal_o   - encoding is legal
module kgp_risc_seq_ctrl_decoder
  import kgp_risc_seq_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output iclass_t     iclass_o,
  output logic [4:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        legal_o
);

  logic [5:0] opcode;
  logic [4:0] funct;
  logic       unused_instr_bits;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[4:0];
  // Register/immediate fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^instr_i[25:5];

  always_comb begin
    iclass_o  = CL_ILL;
    alu_op_o  = ALU_ADD;
    alu_src_o = 1'b0;
    case (opcode)
      OP_RALU: begin iclass_o = CL_RALU; alu_op_o = funct; end
      OP_IALU: begin iclass_o = CL_IALU; alu_op_o = funct; alu_src_o = 1'b1; end
      OP_LW:   begin iclass_o = CL_LW; alu_src_o = 1'b1; end
      OP_SW:   begin iclass_o = CL_SW; alu_src_o = 1'b1; end
      OP_UNC: begin
        case (funct)
          F_B:     iclass_o = CL_B;
          F_BR:    iclass_o = CL_BR;
          F_BL:    iclass_o = CL_BL;
          default: iclass_o = CL_ILL;
        endcase
      end
      OP_COND: iclass_o = (funct <= F_BNCY) ? CL_COND : CL_ILL;
      OP_HALT: iclass_o = CL_HALT;
      default: iclass_o = CL_ILL;
    endcase
    legal_o = (iclass_o != CL_ILL);
  end

endmodule

// File: rtl/kgp_risc_seq_ctrl.sv
// Multi-cycle control sequencer for the KGP-RISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables and mux selects, and handshakes with instruction/data memory.
// Stops in HALT on a HALT instruction, or in ERR on an illegal encoding or a
// memory request left unacknowledged for MEM_TIMEOUT cycles.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   run                       - start/continue, sampled in IDLE and at retire
//   instr                     - instruction word from IR
//   flag_z/flag_n/flag_c      - registered ALU flags
//   imem_ack, dmem_ack        - memory acknowledges
//   imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
//   alu_src, alu_op, flags_we - datapath/memory control
//   halted, err               - core stopped / stopped on error
//   instret                   - retired instruction count (wraps)
module kgp_risc_seq_ctrl
  import kgp_risc_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             flag_c,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [4:0]       alu_op,
  output logic             flags_we,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instret
);

  // Counter only needs to reach MEM_TIMEOUT-1: the last unacked cycle is
  // detected by value, and the ERR transition replaces the final increment.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  iclass_t           cls_q, cls_d;
  logic [4:0]        alu_op_q, alu_op_d;
  logic              alu_src_q, alu_src_d;
  logic [4:0]        funct_q, funct_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  iclass_t    dec_cls;
  logic [4:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_legal;
  logic       retire;
  logic       wait_last;

  kgp_risc_seq_ctrl_decoder u_dec (
    .instr_i   (instr),
    .iclass_o  (dec_cls),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src),
    .legal_o   (dec_legal)
  );

  assign wait_last = (wait_q == WAIT_LAST);
  assign instret   = instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= CL_RALU;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      funct_q   <= '0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      funct_q   <= funct_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_op_d  = alu_op_q;
    alu_src_d = alu_src_q;
    funct_d   = funct_q;
    wait_d    = wait_q;
    instret_d = instret_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_src   = 1'b0;
    alu_op    = '0;
    flags_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
          wait_d  = '0;
        end else if (wait_last) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        cls_d     = dec_cls;
        alu_op_d  = dec_alu_op;
        alu_src_d = dec_alu_src;
        funct_d   = instr[4:0];
        if (!dec_legal)                state_d = ST_ERR;
        else if (dec_cls == CL_HALT)   state_d = ST_HALT;
        else                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_op  = alu_op_q;
        alu_src = alu_src_q;
        case (cls_q)
          CL_RALU, CL_IALU: begin flags_we = 1'b1; state_d = ST_WB; end
          CL_LW, CL_SW:     begin state_d = ST_MEM; wait_d = '0; end
          CL_BL:            state_d = ST_WB;
          CL_B:  begin pc_we = 1'b1; pc_src = PC_IMM; retire = 1'b1; end
          CL_BR: begin pc_we = 1'b1; pc_src = PC_REG; retire = 1'b1; end
          CL_COND: begin
            pc_we  = 1'b1;
            pc_src = cond_taken(funct_q, flag_z, flag_n, flag_c) ? PC_IMM : PC_SEQ;
            retire = 1'b1;
          end
          default: state_d = ST_ERR;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_SW);
        if (dmem_ack) begin
          wait_d = '0;
          if (cls_q == CL_SW) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_last) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        case (cls_q)
          CL_LW:   wb_sel = WB_MEM;
          CL_BL:   begin wb_sel = WB_LINK; pc_src = PC_IMM; end
          default: wb_sel = WB_ALU;
        endcase
        retire = 1'b1;
      end
      default: ;
    endcase

    halted = (state_q == ST_HALT) || (state_q == ST_ERR);
    err    = (state_q == ST_ERR);

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      state_d   = run ? ST_FETCH : ST_IDLE;
      wait_d    = '0;
    end
  end

endmodule

// File: tb/tb_kgp_risc_seq_ctrl.sv
module tb_kgp_risc_seq_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, run, flag_z, flag_n, flag_c, imem_ack, dmem_ack;
  logic [31:0]   instr;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src, flags_we, halted, err;
  logic [1:0]    pc_src, wb_sel;
  logic [4:0]    alu_op;
  logic [CW-1:0] instret;

  kgp_risc_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op), .flags_we(flags_we),
    .halted(halted), .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic z, n, c;
    int   iw, dw;
    bit   noise;
    int   cyc;
    int   reg_we;
    int   wb_sel;
    int   pc_src;
    int   flags_we;
    int   dreq;
    int   dwe;
    bit   chk_alu;
    int   alu_op;
    int   alu_src;
  } vec_t;

  vec_t vecs[18];
  vec_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   retired = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int fn);
    logic [5:0] o;
    logic [4:0] f;
    o = op[5:0];
    f = fn[4:0];
    return {o, 21'd0, f};
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic z, input logic n, input logic c,
                               input int iw, input int dw, input bit noise, input int cyc,
                               input int rw, input int wb, input int pcs, input int fl,
                               input int dreq, input int dwe, input bit chk, input int aop, input int src);
    vec_t v;
    v.instr = ins; v.z = z; v.n = n; v.c = c; v.iw = iw; v.dw = dw; v.noise = noise;
    v.cyc = cyc; v.reg_we = rw; v.wb_sel = wb; v.pc_src = pcs; v.flags_we = fl;
    v.dreq = dreq; v.dwe = dwe; v.chk_alu = chk; v.alu_op = aop; v.alu_src = src;
    return v;
  endfunction

  // Control outputs excluding halted/err.
  function automatic logic [16:0] ctl();
    return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, wb_sel, alu_src, alu_op, flags_we};
  endfunction

  // Drives one instruction through the DUT acting as both memories; called
  // just after the clock edge that enters FETCH.
  task automatic run_vec(input vec_t e, input int idx);
    int iwc, dwc, cyc, o_irn, o_ir_at, o_reg, o_fl, o_dreq, o_dwe, o_wb, o_pcs, o_alu, o_src;
    bit done;
    vec_t x;
    string t;
    iwc = 0; dwc = 0; cyc = 0; o_irn = 0; o_ir_at = 0; o_reg = 0; o_fl = 0; o_dreq = 0;
    o_dwe = 0; o_wb = 0; o_pcs = 0; o_alu = 0; o_src = 0; done = 0;
    t = $sformatf("v%0d", idx);
    instr = e.instr; flag_z = e.z; flag_n = e.n; flag_c = e.c;
    sb_q.push_back(e);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (imem_req) begin
        if (iwc == e.iw) imem_ack = 1'b1; else iwc++;
      end else if (e.noise) imem_ack = 1'b1;
      if (dmem_req) begin
        if (dwc == e.dw) dmem_ack = 1'b1; else dwc++;
      end else if (e.noise) dmem_ack = 1'b1;
      #1;
      if (ir_we) begin o_irn++; o_ir_at = cyc; end
      if (flags_we) o_fl++;
      if (dmem_req) o_dreq++;
      if (dmem_we) o_dwe = 1;
      if (reg_we) begin o_reg++; o_wb = int'(wb_sel); end
      if (cyc == e.iw + 3) begin o_alu = int'(alu_op); o_src = int'(alu_src); end
      if (pc_we) begin done = 1; o_pcs = int'(pc_src); end
    end
    x = sb_q.pop_front();
    check({t, " retired"}, done, 1);
    if (done) begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      retired++;
      check({t, " cycles"}, cyc, x.cyc);
      check({t, " ir_we count"}, o_irn, 1);
      check({t, " ir_we cycle"}, o_ir_at, x.iw + 1);
      check({t, " flags_we"}, o_fl, x.flags_we);
      check({t, " reg_we"}, o_reg, x.reg_we);
      check({t, " wb_sel"}, o_wb, x.wb_sel);
      check({t, " pc_src"}, o_pcs, x.pc_src);
      check({t, " dmem_req cycles"}, o_dreq, x.dreq);
      check({t, " dmem_we"}, o_dwe, x.dwe);
      if (x.chk_alu) begin
        check({t, " alu_op"}, o_alu, x.alu_op);
        check({t, " alu_src"}, o_src, x.alu_src);
      end
      check({t, " instret"}, instret, retired % 16);
    end
  endtask

  task automatic do_reset(input logic run_v);
    @(negedge clk);
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = run_v;
  endtask

  task automatic cyc_ack(input logic ia, input logic da);
    @(negedge clk);
    imem_ack = ia;
    dmem_ack = da;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ill[3];
    //                ins        z n c  iw dw nz  cyc rw wb pcs fl dreq dwe chk aop src
    vecs[0]  = mkv(mk(0,0),  0,0,0, 0, 0, 0,  4,  1, 0, 0,  1, 0,   0,  1,  0,  0);
    vecs[1]  = mkv(mk(0,5),  0,0,0, 2, 0, 0,  6,  1, 0, 0,  1, 0,   0,  1,  5,  0);
    vecs[2]  = mkv(mk(1,3),  0,0,0, 0, 0, 0,  4,  1, 0, 0,  1, 0,   0,  1,  3,  1);
    vecs[3]  = mkv(mk(2,9),  0,0,0, 0, 3, 0,  8,  1, 1, 0,  0, 4,   0,  1,  0,  1);
    vecs[4]  = mkv(mk(2,0),  0,0,0, 3, 0, 1,  8,  1, 1, 0,  0, 1,   0,  1,  0,  1);
    vecs[5]  = mkv(mk(3,0),  0,0,0, 0, 1, 0,  5,  0, 0, 0,  0, 2,   1,  1,  0,  1);
    vecs[6]  = mkv(mk(4,0),  0,0,0, 0, 0, 0,  3,  0, 0, 1,  0, 0,   0,  0,  0,  0);
    vecs[7]  = mkv(mk(4,1),  0,0,0, 0, 0, 0,  3,  0, 0, 2,  0, 0,   0,  0,  0,  0);
    vecs[8]  = mkv(mk(4,2),  0,0,0, 0, 0, 0,  4,  1, 2, 1,  0, 0,   0,  0,  0,  0);
    vecs[9]  = mkv(mk(5,1),  1,0,0, 0, 0, 0,  3,  0, 0, 1,  0, 0,   0,  0,  0,  0);
    vecs[10] = mkv(mk(5,1),  0,1,1, 0, 0, 0,  3,  0, 0, 0,  0, 0,   0,  0,  0,  0);
    vecs[11] = mkv(mk(5,0),  0,1,0, 0, 0, 0,  3,  0, 0, 1,  0, 0,   0,  0,  0,  0);
    vecs[12] = mkv(mk(5,0),  1,0,1, 0, 0, 0,  3,  0, 0, 0,  0, 0,   0,  0,  0,  0);
    vecs[13] = mkv(mk(5,2),  0,1,1, 0, 0, 0,  3,  0, 0, 1,  0, 0,   0,  0,  0,  0);
    vecs[14] = mkv(mk(5,2),  1,0,0, 0, 0, 0,  3,  0, 0, 0,  0, 0,   0,  0,  0,  0);
    vecs[15] = mkv(mk(5,3),  0,0,1, 1, 0, 0,  4,  0, 0, 1,  0, 0,   0,  0,  0,  0);
    vecs[16] = mkv(mk(5,4),  0,0,1, 0, 0, 0,  3,  0, 0, 0,  0, 0,   0,  0,  0,  0);
    vecs[17] = mkv(mk(5,4),  1,1,0, 0, 0, 0,  3,  0, 0, 1,  0, 0,   0,  0,  0,  0);

    rst = 1'b1; run = 1'b0; instr = '0; flag_z = 0; flag_n = 0; flag_c = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, and IDLE holds while run is low.
    cyc_ack(1, 1);
    check("reset ctl", ctl(), 0);
    check("reset status", {halted, err}, 0);
    check("reset instret", instret, 0);
    cyc_ack(0, 0);
    check("idle hold imem_req", imem_req, 0);

    run = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // run dropped mid-instruction: instruction completes, then IDLE.
    do_reset(1);
    instr = mk(0, 1);
    cyc_ack(0, 0);
    cyc_ack(1, 0);
    check("E ir_we", ir_we, 1);
    cyc_ack(0, 0);
    run = 1'b0;
    cyc_ack(0, 0);
    check("E flags_we", flags_we, 1);
    cyc_ack(0, 0);
    check("E wb reg_we/pc_we", {reg_we, pc_we}, 2'b11);
    cyc_ack(1, 0);
    check("E idle after retire", ctl(), 0);
    check("E instret", instret, 1);
    cyc_ack(0, 0);
    check("E still idle", imem_req, 0);

    // add then HALT: halted without error, instret frozen.
    do_reset(1);
    instr = mk(0, 0);
    cyc_ack(0, 0);
    cyc_ack(1, 0);
    cyc_ack(0, 0);
    cyc_ack(0, 0);
    cyc_ack(0, 0);
    check("A add pc_we", pc_we, 1);
    instr = mk(6, 0);
    cyc_ack(1, 0);
    cyc_ack(0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc_ack(1, 1);
      check($sformatf("A halt status %0d", k), {halted, err}, 2'b10);
      check($sformatf("A halt ctl %0d", k), ctl(), 0);
      check($sformatf("A halt instret %0d", k), instret, 1);
    end

    // Illegal encodings end in ERR right after DECODE.
    ill[0] = mk(7, 0);
    ill[1] = mk(5, 5);
    ill[2] = mk(4, 3);
    for (int k = 0; k < 3; k++) begin
      do_reset(1);
      instr = ill[k];
      cyc_ack(0, 0);
      cyc_ack(1, 0);
      cyc_ack(0, 0);
      check($sformatf("B decode not stopped %0d", k), halted, 0);
      cyc_ack(0, 0);
      check($sformatf("B err status %0d", k), {halted, err}, 2'b11);
      check($sformatf("B err ctl %0d", k), ctl(), 0);
    end

    // Instruction fetch never acknowledged: ERR after MEM_TIMEOUT cycles.
    do_reset(1);
    instr = mk(0, 0);
    cyc_ack(0, 0);
    for (int k = 0; k < TO; k++) begin
      cyc_ack(0, 0);
      check($sformatf("C imem_req held %0d", k), imem_req, 1);
    end
    cyc_ack(0, 0);
    check("C timeout status", {halted, err}, 2'b11);
    check("C timeout req dropped", imem_req, 0);
    for (int k = 0; k < 3; k++) begin
      run = k[0];
      cyc_ack(1, 1);
      check($sformatf("C err sticky %0d", k), {halted, err, ir_we}, 3'b110);
    end
    do_reset(0);
    cyc_ack(0, 0);
    check("C after rst status", {halted, err}, 0);
    check("C after rst ctl", ctl(), 0);

    // Reset while a store waits in MEM.
    do_reset(1);
    instr = mk(3, 0);
    cyc_ack(0, 0);
    cyc_ack(1, 0);
    cyc_ack(0, 0);
    cyc_ack(0, 0);
    cyc_ack(0, 0);
    check("D in mem", {dmem_req, dmem_we}, 2'b11);
    rst = 1'b1;
    cyc_ack(0, 1);
    check("D rst ctl", ctl(), 0);
    check("D rst instret", instret, 0);
    rst = 1'b0;
    run = 1'b0;
    cyc_ack(0, 1);
    check("D idle ctl", ctl(), 0);
    check("D idle status", {halted, err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
